// File: rtl/sliding_window_buffer.sv
// Circular window buffer: PAR_WRITE words in per write, PAR_READ-word window out, run-time stride pop.
// Optional sticky error flags (err_ovf, err_udf) are enabled by defining SWB_ERR_FLAGS_EN.
module sliding_window_buffer #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned PAR_WRITE = 1,
    parameter int unsigned PAR_READ  = 4,
    parameter int unsigned STRIDE_W  = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         write_en,
    input  logic [WIDTH*PAR_WRITE-1:0]   din,
    output logic                         ready,
    input  logic                         read_en,
    input  logic [STRIDE_W-1:0]          stride,
    output logic [WIDTH*PAR_READ-1:0]    dout,
    output logic                         valid,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    input  logic                         flush
`ifdef SWB_ERR_FLAGS_EN
    ,
    output logic                         err_ovf,
    output logic                         err_udf
`endif
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned SW = (STRIDE_W > CW) ? STRIDE_W : CW;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wptr_q, wptr_d;
    logic [PW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [CW-1:0]    pop;
    logic             wacc, racc, stride_big;

    // Status decodes come only from registered occupancy
    assign ready = (count_q <= CW'(DEPTH - PAR_WRITE));
    assign valid = (count_q >= CW'(PAR_READ));
    assign count = count_q;

    assign wacc       = write_en & ready;
    assign racc       = read_en & valid;
    assign stride_big = (SW'(stride) > SW'(PAR_READ));
    assign pop        = stride_big ? CW'(PAR_READ) : CW'(stride);

    always_comb begin
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (wacc) begin
                for (int j = 0; j < int'(PAR_WRITE); j++) begin
                    mem_d[PW'(wptr_q + PW'(j))] = din[j*WIDTH +: WIDTH];
                end
                wptr_d = wptr_q + PW'(PAR_WRITE);
            end
            if (racc) begin
                rptr_d = rptr_q + PW'(pop);
            end
            count_d = count_q + (wacc ? CW'(PAR_WRITE) : CW'(0)) - (racc ? pop : CW'(0));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q   <= '{default: '0};
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Window is a combinational view starting at the read pointer, wrapping modulo DEPTH
    always_comb begin
        dout = '0;
        for (int i = 0; i < int'(PAR_READ); i++) begin
            dout[i*WIDTH +: WIDTH] = mem_q[PW'(rptr_q + PW'(i))];
        end
    end

`ifdef SWB_ERR_FLAGS_EN
    logic err_ovf_q, err_ovf_d;
    logic err_udf_q, err_udf_d;

    always_comb begin
        err_ovf_d = err_ovf_q;
        err_udf_d = err_udf_q;
        if (flush) begin
            err_ovf_d = 1'b0;
            err_udf_d = 1'b0;
        end else begin
            if (write_en && !ready) err_ovf_d = 1'b1;
            if ((read_en && !valid) || (racc && stride_big)) err_udf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_ovf_q <= 1'b0;
            err_udf_q <= 1'b0;
        end else begin
            err_ovf_q <= err_ovf_d;
            err_udf_q <= err_udf_d;
        end
    end

    assign err_ovf = err_ovf_q;
    assign err_udf = err_udf_q;
`endif

endmodule

// File: doc/sliding_window_buffer.md
Name: sliding_window_buffer

Overview:
Parametrised circular buffer for the CNN processing element. Accepts PAR_WRITE words per write and presents a window of PAR_READ consecutive words. On each read it pops a run-time selectable STRIDE of words, so overlapping convolution windows are delivered without re-fetching. It is the successor to the fixed-pop parallel buffer and sits between the input/filter feeders and the PE multiply stage.

Parameters:
WIDTH, 16, bits per word
DEPTH, 16, storage in words; power of 2; must be >= PAR_READ + PAR_WRITE
PAR_WRITE, 1, words accepted per write handshake
PAR_READ, 4, words presented per window (window size)
STRIDE_W, 3, width of the stride input; must be able to encode PAR_READ

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
write_en  input  1  producer requests write of din
din  input  WIDTH*PAR_WRITE  write data; word 0 = din[0:WIDTH-1], lowest bit index first
ready  output  1  space for PAR_WRITE words
read_en  input  1  consumer accepts current window
stride  input  STRIDE_W  words to pop on an accepted read (0..PAR_READ)
dout  output  WIDTH*PAR_READ  window; word i = dout[i*WIDTH : i*WIDTH+WIDTH-1]
valid  output  1  at least PAR_READ words stored
count  output  $clog2(DEPTH+1)  current occupancy in words
flush  input  1  synchronous clear of contents

Behaviour:
- Storage: DEPTH x WIDTH array, write pointer wptr and read pointer rptr (log2 DEPTH bits each, wrap modulo DEPTH), plus occupancy counter count.
- Reset (async, rst=1): wptr=0, rptr=0, count=0, all memory words=0, so dout=0, valid=0, ready=1.
- ready = (DEPTH - count) >= PAR_WRITE. valid = count >= PAR_READ. Both are decoded from registered count and are not combinationally dependent on read_en or write_en.
- Write accept (wacc) = write_en & ready. On the clock edge, din word j goes to mem[(wptr+j) mod DEPTH] for j=0..PAR_WRITE-1, and wptr += PAR_WRITE. If write_en=1 while ready=0, the write is dropped and no state changes.
- dout word i = mem[(rptr+i) mod DEPTH], read combinationally. Window contents are defined only while valid=1.
- Read accept (racc) = read_en & valid. pop = min(stride, PAR_READ). On the clock edge rptr += pop. stride=0 is a legal no-op read: the window stays the same. If read_en=1 while valid=0, the read is ignored.
- Count update: count_next = count + (wacc ? PAR_WRITE : 0) - (racc ? pop : 0). Simultaneous read and write in one cycle are both honoured.
- Latency: words written at edge n appear on dout after edge n, in the cycle after the write. valid rises in that same cycle if the threshold is met.
- Wrap-around: a window or write that spans index DEPTH-1 -> 0 is contiguous modulo DEPTH. There is no bubble.
- Full: count=DEPTH-PAR_WRITE+1..DEPTH gives ready=0. A simultaneous read does not raise ready in the same cycle, because ready is registered-count based.
- Empty / partial: count<PAR_READ gives valid=0. dout still shows stale or partial data and must be ignored.
- Flush (synchronous): wptr=rptr=count=0. Memory is not cleared. Flush has priority over a same-cycle write and read, which are discarded.
- Reset mid-transfer: state returns immediately to the reset values. No partial write completes.
- count never exceeds DEPTH and never goes negative. The verifier asserts this each cycle.

Optional Feature:
Macro SWB_ERR_FLAGS_EN.
- Defined: adds two outputs, err_ovf (1 bit) and err_udf (1 bit), both reset to 0. err_ovf is a sticky flag set when write_en=1 & ready=0. err_udf is a sticky flag set when read_en=1 & valid=0, or when stride > PAR_READ on an accepted read. Both flags clear only on rst or flush.
- Undefined: the ports do not exist. Dropped requests are silent, and an out-of-range stride is silently clamped to PAR_READ.

Test Plan:
- Reset then idle (default params): count=0, valid=0, ready=1, dout=0 for 5 cycles.
- Write 1,2,3,4 on consecutive cycles -> valid rises the cycle after the 4th write; dout = {1,2,3,4}; count=4.
- Continue writing 5..8, then read with stride=1 three times -> windows {1,2,3,4}, {2,3,4,5}, {3,4,5,6}; count 8->7->6->5.
- Fill to 16, then write_en=1 -> ready=0, the write is dropped, count stays 16. Simultaneous read stride=2 with write_en: count=14 next cycle, and ready=1 only after that.
- Wrap: with rptr=14 and 4 words valid, dout = {mem[14],mem[15],mem[0],mem[1]}. Stride=4 read -> rptr=2, count decreases by 4.
- Flush with write_en=1 and read_en=1 in the same cycle -> count=0, valid=0, ready=1. With SWB_ERR_FLAGS_EN, an earlier overflow sets err_ovf=1, which stays set until the flush clears it.
